// File: rtl/conv_encoder.sv
// Rate-1/2 K=7 convolutional encoder (g0=133o, g1=171o) with 802.11a puncturing
// to 2/3 and 3/4; one data bit per clock, coded bits packed LSB-first into output words.
module conv_encoder #(
   parameter int IN_WIDTH  = 24,
   parameter int OUT_WIDTH = 48
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic [IN_WIDTH-1:0]  s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   input  logic                 s_axis_tlast,
   input  logic [1:0]           s_axis_tuser,
   output logic [OUT_WIDTH-1:0] m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tlast
);

   localparam int IW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
   localparam int CW = $clog2(OUT_WIDTH + 2);
   localparam int GW = OUT_WIDTH + 2;

   logic [IN_WIDTH-1:0]  hold_data_q, hold_data_d;
   logic                 hold_valid_q, hold_valid_d;
   logic                 hold_last_q, hold_last_d;
   logic [IW-1:0]        bit_idx_q, bit_idx_d;
   logic [1:0]           rate_q, rate_d;
   logic                 pkt_start_q, pkt_start_d;
   logic                 ready_en_q, ready_en_d;
   logic [5:0]           enc_q, enc_d;
   logic [1:0]           phase_q, phase_d;
   logic [OUT_WIDTH-1:0] gather_q, gather_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 flush_q, flush_d;
   logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
   logic                 out_valid_q, out_valid_d;
   logic                 out_last_q, out_last_d;

   logic          enc_bit, coded_a, coded_b;
   logic [1:0]    emit_n, emit_bits, phase_next;
   logic [CW-1:0] total;
   logic [GW-1:0] merged;
   logic          out_free, last_bit, eop, word_full, word_done, encode_go;

   // Both streams follow AXI-Stream: a beat moves on the rising edge where valid
   // and ready are both high; the master holds data/last stable until then.
   assign s_axis_tready = ready_en_q && !hold_valid_q;
   assign m_axis_tdata  = out_data_q;
   assign m_axis_tvalid = out_valid_q;
   assign m_axis_tlast  = out_last_q;

   assign enc_bit = hold_data_q[bit_idx_q];
   assign coded_a = enc_bit ^ enc_q[1] ^ enc_q[2] ^ enc_q[4] ^ enc_q[5];
   assign coded_b = enc_bit ^ enc_q[0] ^ enc_q[1] ^ enc_q[2] ^ enc_q[5];

   always_comb begin
      emit_n     = 2'd2;
      emit_bits  = {coded_b, coded_a};
      phase_next = 2'd0;
      case (rate_q)
         2'd1: begin
            phase_next = (phase_q == 2'd1) ? 2'd0 : 2'd1;
            if (phase_q == 2'd1) begin
               emit_n    = 2'd1;
               emit_bits = {1'b0, coded_a};
            end
         end
         2'd2: begin
            phase_next = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
            if (phase_q == 2'd1) begin
               emit_n    = 2'd1;
               emit_bits = {1'b0, coded_a};
            end else if (phase_q == 2'd2) begin
               emit_n    = 2'd1;
               emit_bits = {1'b0, coded_b};
            end
         end
         default: ;
      endcase
   end

   assign out_free  = !out_valid_q || m_axis_tready;
   assign last_bit  = (bit_idx_q == IW'(IN_WIDTH - 1));
   assign eop       = last_bit && hold_last_q;
   assign total     = count_q + CW'(emit_n);
   // Up to one coded bit can spill past OUT_WIDTH; it lands in merged[GW-1:OUT_WIDTH].
   assign merged    = {2'b00, gather_q} | ({{OUT_WIDTH{1'b0}}, emit_bits} << count_q);
   assign word_full = (total >= CW'(OUT_WIDTH));
   assign word_done = word_full || eop;
   assign encode_go = hold_valid_q && !flush_q && (!word_done || out_free);

   always_comb begin
      hold_data_d  = hold_data_q;
      hold_valid_d = hold_valid_q;
      hold_last_d  = hold_last_q;
      bit_idx_d    = bit_idx_q;
      rate_d       = rate_q;
      pkt_start_d  = pkt_start_q;
      ready_en_d   = 1'b1;
      enc_d        = enc_q;
      phase_d      = phase_q;
      gather_d     = gather_q;
      count_d      = count_q;
      flush_d      = flush_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;

      if (out_valid_q && m_axis_tready) begin
         out_valid_d = 1'b0;
      end

      // A packet end whose final bit spilled over leaves one bit to ship alone.
      if (flush_q && out_free) begin
         out_data_d  = gather_q;
         out_valid_d = 1'b1;
         out_last_d  = 1'b1;
         gather_d    = '0;
         count_d     = '0;
         flush_d     = 1'b0;
      end

      if (encode_go) begin
         enc_d     = eop ? 6'd0 : {enc_q[4:0], enc_bit};
         phase_d   = eop ? 2'd0 : phase_next;
         bit_idx_d = last_bit ? '0 : bit_idx_q + IW'(1);
         if (last_bit) hold_valid_d = 1'b0;
         if (eop) pkt_start_d = 1'b1;
         if (word_full) begin
            out_data_d    = merged[OUT_WIDTH-1:0];
            out_valid_d   = 1'b1;
            out_last_d    = eop && (total == CW'(OUT_WIDTH));
            gather_d      = '0;
            gather_d[1:0] = merged[GW-1:OUT_WIDTH];
            count_d       = total - CW'(OUT_WIDTH);
            flush_d       = eop && (total != CW'(OUT_WIDTH));
         end else if (eop) begin
            out_data_d  = merged[OUT_WIDTH-1:0];
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
            gather_d    = '0;
            count_d     = '0;
         end else begin
            gather_d = merged[OUT_WIDTH-1:0];
            count_d  = total;
         end
      end

      if (s_axis_tvalid && s_axis_tready) begin
         hold_data_d  = s_axis_tdata;
         hold_valid_d = 1'b1;
         hold_last_d  = s_axis_tlast;
         bit_idx_d    = '0;
         if (pkt_start_q) begin
            rate_d      = s_axis_tuser;
            pkt_start_d = 1'b0;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         hold_data_q  <= '0;
         hold_valid_q <= 1'b0;
         hold_last_q  <= 1'b0;
         bit_idx_q    <= '0;
         rate_q       <= 2'd0;
         pkt_start_q  <= 1'b1;
         ready_en_q   <= 1'b0;
         enc_q        <= 6'd0;
         phase_q      <= 2'd0;
         gather_q     <= '0;
         count_q      <= '0;
         flush_q      <= 1'b0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
      end else begin
         hold_data_q  <= hold_data_d;
         hold_valid_q <= hold_valid_d;
         hold_last_q  <= hold_last_d;
         bit_idx_q    <= bit_idx_d;
         rate_q       <= rate_d;
         pkt_start_q  <= pkt_start_d;
         ready_en_q   <= ready_en_d;
         enc_q        <= enc_d;
         phase_q      <= phase_d;
         gather_q     <= gather_d;
         count_q      <= count_d;
         flush_q      <= flush_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
      end
   end

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder: hand-computed coded words, rates 1/2, 2/3, 3/4,
// multi-beat state continuity, output backpressure and reset in mid-packet.
module tb_conv_encoder;

   localparam int IW = 24;
   localparam int OW = 48;

   logic          aclk = 1'b0;
   logic          areset;
   logic [IW-1:0] s_axis_tdata;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic          s_axis_tlast;
   logic [1:0]    s_axis_tuser;
   logic [OW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;

   logic [OW:0] exp_q[$];
   int chk_cnt = 0;
   int err_cnt = 0;

   conv_encoder #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tuser  (s_axis_tuser),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast)
   );

   // Clock and watchdog
   always #5 aclk = ~aclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", chk_cnt, err_cnt);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every valid output cycle must show the head of exp_q, stall or not.
   always @(negedge aclk) begin
      if (!areset && m_axis_tvalid) begin
         if (exp_q.size() == 0) begin
            check("spare_beat_valid", 64'(m_axis_tvalid), 64'd0);
         end else begin
            check("beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(exp_q[0]));
            if (m_axis_tready) void'(exp_q.pop_front());
         end
      end
   end

   // Driver tasks
   task automatic do_reset();
      areset = 1'b1;
      @(posedge aclk); #1;
      check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_s_tready", 64'(s_axis_tready), 64'd0);
      check("rst_m_tdata",  64'(m_axis_tdata),  64'd0);
      check("rst_m_tlast",  64'(m_axis_tlast),  64'd0);
      @(posedge aclk); #1;
      areset = 1'b0;
   endtask

   task automatic send_beat(input logic [IW-1:0] data, input logic last, input logic [1:0] user);
      int n;
      n = 0;
      s_axis_tdata  = data;
      s_axis_tlast  = last;
      s_axis_tuser  = user;
      s_axis_tvalid = 1'b1;
      @(negedge aclk);
      while (!s_axis_tready && n < 300) begin
         @(negedge aclk);
         n++;
      end
      if (n >= 300) check("send_timeout_s_tready", 64'(s_axis_tready), 64'd1);
      @(posedge aclk); #1;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 2'd0;
   endtask

   task automatic expect_beat(input logic last, input logic [OW-1:0] data);
      exp_q.push_back({last, data});
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(posedge aclk);
         n++;
      end
      check(tag, 64'(exp_q.size()), 64'd0);
      repeat (4) @(posedge aclk);
      #1;
   endtask

   initial begin
      int lat;
      areset        = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 2'd0;
      m_axis_tready = 1'b1;
      do_reset();

      // All-zero, three beats, rate 1/2: each beat fills one word exactly
      expect_beat(1'b0, 48'h0);
      expect_beat(1'b0, 48'h0);
      expect_beat(1'b1, 48'h0);
      send_beat(24'h000000, 1'b0, 2'd0);
      send_beat(24'h000000, 1'b0, 2'd0);
      send_beat(24'h000000, 1'b1, 2'd0);
      drain("drain_zero");

      // Impulse at rate 1/2, plus the accept-to-valid latency (valid after 24 encode edges)
      expect_beat(1'b1, 48'h0000_0000_34FB);
      send_beat(24'h000001, 1'b1, 2'd0);
      lat = 0;
      while (!m_axis_tvalid && lat < 100) begin
         @(negedge aclk);
         lat++;
      end
      check("latency_negedges", 64'(lat), 64'd25);
      drain("drain_imp_r12");

      // Impulse at rate 2/3 and 3/4
      expect_beat(1'b1, 48'h0000_0000_073B);
      send_beat(24'h000001, 1'b1, 2'd1);
      drain("drain_imp_r23");
      expect_beat(1'b1, 48'h0000_0000_033B);
      send_beat(24'h000001, 1'b1, 2'd2);
      drain("drain_imp_r34");

      // Encoder state carried across beats
      expect_beat(1'b0, 48'hC000_0000_0000);
      expect_beat(1'b1, 48'h0000_0000_0D3E);
      send_beat(24'h800000, 1'b0, 2'd0);
      send_beat(24'h000000, 1'b1, 2'd0);
      drain("drain_two_beat");

      // Rate is taken from the first beat only; the second beat's tuser is ignored
      expect_beat(1'b0, 48'h033B_0000_0000);
      expect_beat(1'b1, 48'h0000_0000_0000);
      send_beat(24'h000000, 1'b0, 2'd2);
      send_beat(24'h000001, 1'b1, 2'd0);
      drain("drain_rate_latch");

      // Output backpressure for 100 cycles during the two-beat case
      m_axis_tready = 1'b0;
      expect_beat(1'b0, 48'hC000_0000_0000);
      expect_beat(1'b1, 48'h0000_0000_0D3E);
      send_beat(24'h800000, 1'b0, 2'd0);
      send_beat(24'h000000, 1'b1, 2'd0);
      repeat (70) @(posedge aclk);
      #1;
      check("stall_s_tready", 64'(s_axis_tready), 64'd0);
      check("stall_m_tvalid", 64'(m_axis_tvalid), 64'd1);
      m_axis_tready = 1'b1;
      drain("drain_backpressure");

      // Reset in the middle of a packet, then a clean impulse
      send_beat(24'hFFFFFF, 1'b0, 2'd2);
      repeat (8) @(posedge aclk);
      #1;
      do_reset();
      expect_beat(1'b1, 48'h0000_0000_34FB);
      send_beat(24'h000001, 1'b1, 2'd0);
      drain("drain_after_reset");

      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
      $finish;
   end

endmodule
